mac_wave_sequencer: RTL and testbench

- Bit-serial issue controller for one `mac_unit_8_Wave` column MAC.
- Accepts one dot-product command: per-lane weight magnitudes, signs, and mode flags.
- Walks the weight bit-columns, optionally skipping all-zero columns, and drives `en`, `load_accum`, `column_idx`, `sign`, `w_bit` and `is_pooling` so the MAC's two-stage accumulate pipeline produces a correct result.
- Signals completion with a valid/ready handshake; sits between the tile scheduler and the MAC array.

---
 rtl/mac_wave_pkg.sv | 6 +
 rtl/col_pick.sv | 16 +
 rtl/mac_wave_sequencer.sv | 103 ++++++++++
 tb/tb_mac_wave_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_wave_pkg.sv
// mac_wave_pkg: shared state encoding and column constants for the MAC wave sequencer
package mac_wave_pkg;
  localparam int NCOL = 8;
  localparam int COL_IDX_W = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/col_pick.sv
// col_pick: lowest-set-bit encoder giving index, one-hot and single-bit-remaining flag
module col_pick
  import mac_wave_pkg::*;
(
  input  logic [NCOL-1:0]      i_mask,
  output logic [COL_IDX_W-1:0] o_idx,
  output logic [NCOL-1:0]      o_onehot,
  output logic                 o_last
);
  always_comb begin
    o_idx = '0;
    for (int i = NCOL - 1; i >= 0; i--) if (i_mask[i]) o_idx = COL_IDX_W'(i);
  end
  assign o_onehot = i_mask & (~i_mask + 1'b1);
  assign o_last   = (i_mask != '0) && ((i_mask & (i_mask - 1'b1)) == '0);
endmodule

// File: rtl/mac_wave_sequencer.sv
// mac_wave_sequencer: bit-serial issue controller walking weight columns into one column MAC
module mac_wave_sequencer
  import mac_wave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] cmd_w_mag,
  input  logic [VEC_LENGTH-1:0]            cmd_w_sign,
  input  logic                             cmd_chain,
  input  logic                             cmd_pool,
  input  logic                             cmd_skip_en,
  output logic                             mac_en,
  output logic                             mac_load_accum,
  output logic                             mac_is_pooling,
  output logic [VEC_LENGTH-1:0]            mac_sign,
  output logic [VEC_LENGTH-1:0]            mac_w_bit,
  output logic [COL_IDX_W-1:0]             mac_column_idx,
  output logic                             mac_prev_zero,
  output logic                             act_hold,
  output logic                             done_valid,
  input  logic                             done_ready
);
  localparam logic [NCOL-1:0] FULL_MASK = NCOL'((2 ** DATA_WIDTH) - 1);
  state_t                          r_state, w_state_next;
  logic [NCOL-1:0]                 r_mask, w_or, w_mask_raw, w_mask_new, w_onehot;
  logic [DATA_WIDTH*VEC_LENGTH-1:0] r_mag;
  logic [VEC_LENGTH-1:0]           r_sign, w_col_bits;
  logic                            r_pool, r_prev_zero, w_last, w_accept;
  logic [1:0]                      r_en_cnt;
  logic [COL_IDX_W-1:0]            w_idx;
  logic [NCOL-1:0]                 w_cmd_lane [VEC_LENGTH];
  logic [NCOL-1:0]                 w_lane [VEC_LENGTH];
  genvar l;
  for (l = 0; l < VEC_LENGTH; l++) begin : g_lane
    assign w_cmd_lane[l] = NCOL'(cmd_w_mag[l*DATA_WIDTH +: DATA_WIDTH]);
    assign w_lane[l]     = NCOL'(r_mag[l*DATA_WIDTH +: DATA_WIDTH]);
    assign w_col_bits[l] = w_lane[l][w_idx];
  end
  always_comb begin
    w_or = '0;
    for (int i = 0; i < VEC_LENGTH; i++) w_or |= w_cmd_lane[i];
  end
  // An empty mask still issues column 0 so the pipeline always sees a load cycle.
  assign w_mask_raw = cmd_skip_en ? (w_or & FULL_MASK) : FULL_MASK;
  assign w_mask_new = (w_mask_raw == '0) ? NCOL'(1) : w_mask_raw;
  col_pick u_pick (
    .i_mask  (r_mask),
    .o_idx   (w_idx),
    .o_onehot(w_onehot),
    .o_last  (w_last)
  );
  assign cmd_ready      = (r_state == IDLE) || (r_state == DONE && done_ready);
  assign w_accept       = cmd_valid && cmd_ready;
  assign mac_sign       = r_sign;
  assign mac_is_pooling = r_pool;
  assign mac_prev_zero  = r_prev_zero;
  always_comb begin
    w_state_next   = r_state;
    mac_en         = (r_state == ISSUE) || (r_state == DRAIN);
    mac_load_accum = mac_en && (r_en_cnt == 2'd1);
    mac_column_idx = (r_state == ISSUE) ? w_idx : '0;
    mac_w_bit      = (r_state == ISSUE) ? w_col_bits : '0;
    done_valid     = r_state == DONE;
    act_hold       = (r_state != IDLE) || cmd_valid;
    case (r_state)
      IDLE:    w_state_next = cmd_valid ? ISSUE : IDLE;
      ISSUE:   w_state_next = w_last ? DRAIN : ISSUE;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = done_ready ? (cmd_valid ? ISSUE : IDLE) : DONE;
      default: w_state_next = IDLE;
    endcase
  end
  // r_en_cnt counts mac_en cycles (saturating at 2) so the load lands on the second one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_mag       <= '0;
      r_sign      <= '0;
      r_pool      <= 1'b0;
      r_prev_zero <= 1'b0;
      r_en_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mask      <= w_mask_new;
        r_mag       <= cmd_w_mag;
        r_sign      <= cmd_w_sign;
        r_pool      <= cmd_pool;
        r_prev_zero <= !cmd_chain;
        r_en_cnt    <= '0;
      end else begin
        if (r_state == ISSUE) r_mask <= r_mask & ~w_onehot;
        if (mac_en && r_en_cnt != 2'd2) r_en_cnt <= r_en_cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mac_wave_sequencer.sv
// tb_mac_wave_sequencer: directed checks of issue timing, skipping, handshakes and reset abort
module tb_mac_wave_sequencer;
  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_chain, cmd_pool, cmd_skip_en;
  logic [63:0] cmd_w_mag;
  logic [7:0]  cmd_w_sign, mac_sign, mac_w_bit;
  logic        mac_en, mac_load_accum, mac_is_pooling, mac_prev_zero, act_hold;
  logic        done_valid, done_ready;
  logic [2:0]  mac_column_idx;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  mac_wave_sequencer #(.DATA_WIDTH(8), .VEC_LENGTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_mag(cmd_w_mag), .cmd_w_sign(cmd_w_sign), .cmd_chain(cmd_chain),
    .cmd_pool(cmd_pool), .cmd_skip_en(cmd_skip_en), .mac_en(mac_en),
    .mac_load_accum(mac_load_accum), .mac_is_pooling(mac_is_pooling),
    .mac_sign(mac_sign), .mac_w_bit(mac_w_bit), .mac_column_idx(mac_column_idx),
    .mac_prev_zero(mac_prev_zero), .act_hold(act_hold), .done_valid(done_valid),
    .done_ready(done_ready)
  );
  function automatic logic [25:0] pk(input logic en, ld, input logic [2:0] col,
                                     input logic [7:0] wb, input logic dv, cr, ah, ip, pz,
                                     input logic [7:0] sg);
    return {en, ld, col, wb, dv, cr, ah, ip, pz, sg};
  endfunction
  function automatic logic [25:0] got();
    return {mac_en, mac_load_accum, mac_column_idx, mac_w_bit, done_valid, cmd_ready,
            act_hold, mac_is_pooling, mac_prev_zero, mac_sign};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [63:0] mag, input logic [7:0] sg,
                       input logic chain, pool, skip);
    cmd_valid = 1'b1; cmd_w_mag = mag; cmd_w_sign = sg;
    cmd_chain = chain; cmd_pool = pool; cmd_skip_en = skip;
  endtask
  task automatic accept(input logic [63:0] mag, input logic [7:0] sg,
                        input logic chain, pool, skip);
    offer(mag, sg, chain, pool, skip);
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    logic [25:0] exp;
    reset = 1'b1; cmd_valid = 1'b0; done_ready = 1'b0;
    cmd_w_mag = '0; cmd_w_sign = '0; cmd_chain = 0; cmd_pool = 0; cmd_skip_en = 0;
    step(); step();
    exp = pk(0, 0, 3'd0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    checks++;
    if (got() !== exp) begin errors++; $display("FAIL reset got=%h exp=%h", got(), exp); end
    reset = 1'b0;
    step();
  endtask
  task automatic test_full_columns();
    logic [25:0] exp;
    accept({8{8'hFF}}, 8'hA5, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) exp = pk(1, k == 2, 3'(k - 1), 8'hFF, 0, 0, 1, 1, 1, 8'hA5);
      else if (k == 9) exp = pk(1, 0, 3'd0, 8'h00, 0, 0, 1, 1, 1, 8'hA5);
      else exp = pk(0, 0, 3'd0, 8'h00, 1, 0, 1, 1, 1, 8'hA5);
      checks++;
      if (got() !== exp) begin errors++; $display("FAIL full T+%0d got=%h exp=%h", k, got(), exp); end
      if (k < 10) step();
    end
    done_ready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready got=%b exp=1", cmd_ready); end
    step();
    done_ready = 1'b0;
    exp = pk(0, 0, 3'd0, 8'h00, 0, 1, 0, 1, 1, 8'hA5);
    checks++;
    if (got() !== exp) begin errors++; $display("FAIL full_idle got=%h exp=%h", got(), exp); end
  endtask
  task automatic test_skip_columns();
    logic [25:0] exp [4];
    exp[0] = pk(1, 0, 3'd2, 8'hFD, 0, 0, 1, 0, 0, 8'h0F);
    exp[1] = pk(1, 1, 3'd5, 8'hFE, 0, 0, 1, 0, 0, 8'h0F);
    exp[2] = pk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0, 8'h0F);
    exp[3] = pk(0, 0, 3'd0, 8'h00, 1, 0, 1, 0, 0, 8'h0F);
    accept({{6{8'h24}}, 8'h20, 8'h04}, 8'h0F, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got() !== exp[k]) begin errors++; $display("FAIL skip T+%0d got=%h exp=%h", k + 1, got(), exp[k]); end
      if (k < 3) step();
    end
    done_ready = 1'b1; step(); done_ready = 1'b0;
  endtask
  task automatic test_empty_mask();
    logic [25:0] exp [3];
    exp[0] = pk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0, 8'hC3);
    exp[1] = pk(1, 1, 3'd0, 8'h00, 0, 0, 1, 0, 0, 8'hC3);
    exp[2] = pk(0, 0, 3'd0, 8'h00, 1, 0, 1, 0, 0, 8'hC3);
    accept(64'h0, 8'hC3, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got() !== exp[k]) begin errors++; $display("FAIL empty T+%0d got=%h exp=%h", k + 1, got(), exp[k]); end
      if (k < 2) step();
    end
    done_ready = 1'b1; step(); done_ready = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [25:0] exp [4];
    exp[0] = pk(1, 0, 3'd0, 8'h01, 0, 0, 1, 0, 0, 8'h11);
    exp[1] = pk(1, 1, 3'd7, 8'h01, 0, 0, 1, 0, 0, 8'h11);
    exp[2] = pk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0, 8'h11);
    exp[3] = pk(0, 0, 3'd0, 8'h00, 1, 1, 1, 0, 0, 8'h11);
    accept(64'h81, 8'h11, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        offer({8{8'h01}}, 8'h22, 1'b0, 1'b1, 1'b0);
        done_ready = 1'b1;
        #1;
      end
      checks++;
      if (got() !== exp[k]) begin errors++; $display("FAIL b2b_a T+%0d got=%h exp=%h", k + 1, got(), exp[k]); end
      if (k < 3) step();
    end
    step();
    cmd_valid = 1'b0; done_ready = 1'b0;
    exp[0] = pk(1, 0, 3'd0, 8'hFF, 0, 0, 1, 1, 1, 8'h22);
    exp[1] = pk(1, 1, 3'd1, 8'h00, 0, 0, 1, 1, 1, 8'h22);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got() !== exp[k]) begin errors++; $display("FAIL b2b_b T+%0d got=%h exp=%h", k + 1, got(), exp[k]); end
      step();
    end
    repeat (7) step();
    exp[0] = pk(0, 0, 3'd0, 8'h00, 1, 0, 1, 1, 1, 8'h22);
    checks++;
    if (got() !== exp[0]) begin errors++; $display("FAIL b2b_b_done got=%h exp=%h", got(), exp[0]); end
    done_ready = 1'b1; step(); done_ready = 1'b0;
  endtask
  task automatic test_reset_abort();
    logic [25:0] exp;
    int          seen;
    accept({8{8'hFF}}, 8'h5A, 1'b0, 1'b1, 1'b0);
    step(); step();
    exp = pk(1, 0, 3'd2, 8'hFF, 0, 0, 1, 1, 1, 8'h5A);
    checks++;
    if (got() !== exp) begin errors++; $display("FAIL abort_issue3 got=%h exp=%h", got(), exp); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp = pk(0, 0, 3'd0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    checks++;
    if (got() !== exp) begin errors++; $display("FAIL abort_idle got=%h exp=%h", got(), exp); end
    seen = 0;
    done_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (done_valid !== 1'b0) seen++;
      step();
    end
    done_ready = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
  endtask
  task automatic test_done_stall();
    logic [25:0] exp;
    accept(64'h0, 8'h3C, 1'b0, 1'b1, 1'b1);
    step(); step();
    exp = pk(0, 0, 3'd0, 8'h00, 1, 0, 1, 1, 1, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got() !== exp) begin errors++; $display("FAIL stall cyc%0d got=%h exp=%h", k, got(), exp); end
      step();
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    exp = pk(0, 0, 3'd0, 8'h00, 0, 1, 0, 1, 1, 8'h3C);
    checks++;
    if (got() !== exp) begin errors++; $display("FAIL stall_release got=%h exp=%h", got(), exp); end
  endtask
  initial begin
    test_reset();
    test_full_columns();
    test_skip_columns();
    test_empty_mask();
    test_back_to_back();
    test_reset_abort();
    test_done_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
